// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths, MEM-stage FSM states and the
// MEM/WB register layout also consumed by the write-back stage.
package cpu_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned ZERO_REG = 31;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  // 'rd' carries the destination register index (reg is a reserved word).
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] loadedData;
    logic [DATA_W-1:0] result;
    logic              memToReg;
    logic              regWrite;
    logic              valid;
  } memwb_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for an outstanding data-memory request; expire fires on the
// TIMEOUT-th consecutive enabled cycle so the owner can abort on that edge.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cntQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ <= '0;
    end else if (clr) begin
      cntQ <= '0;
    end else if (en) begin
      cntQ <= cntQ + CntW'(1);
    end
  end

  assign expire = en && !clr && (cntQ == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: runs the data-memory req/ack handshake for loads and
// stores and registers the MEM/WB fields; flags misalignment and ack timeouts.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned REG_W    = cpu_pkg::REG_W,
  parameter int unsigned ZERO_REG = cpu_pkg::ZERO_REG,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_W-1:0]  ex_reg,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_reg_write,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_loaded_data,
  output logic [DATA_W-1:0] wb_result,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic              misalign_err,
  output logic              bus_err
);

  mem_state_t stateQ, stateD;

  logic [REG_W-1:0]  capReg;
  logic [DATA_W-1:0] capResult, capStore;
  logic              capWrite, capMemToReg, capRegWrite;

  logic              accept, exIsMem, exMisalign, inAccess, ackDone, timeoutHit;
  logic              wbValidD, wbRegWriteD, wbMemToRegD, misalignSet, busSet;
  logic [REG_W-1:0]  wbRegD;
  logic [DATA_W-1:0] wbLoadedD, wbResultD;

  assign inAccess   = (stateQ == ACCESS);
  // Gated by rst_n so every output reads 0 while reset is held.
  assign ex_ready   = (stateQ == IDLE) && rst_n;
  assign accept     = ex_valid && ex_ready;
  assign exIsMem    = ex_mem_read || ex_mem_write;
  assign exMisalign = (ex_result[2:0] != 3'b000);
  assign ackDone    = inAccess && dm_ack;

  assign dm_req   = inAccess;
  assign dm_we    = capWrite;
  assign dm_addr  = capResult[ADDR_W-1:0];
  assign dm_wdata = capStore;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!inAccess || dm_ack),
    .en    (inAccess && !dm_ack),
    .expire(timeoutHit)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (accept && exIsMem && !exMisalign) stateD = ACCESS;
      ACCESS:  if (dm_ack || timeoutHit) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Unless something retires this edge, non-handshake wb fields hold.
  always_comb begin
    wbValidD    = 1'b0;
    wbRegWriteD = 1'b0;
    wbRegD      = wb_reg;
    wbLoadedD   = wb_loaded_data;
    wbResultD   = wb_result;
    wbMemToRegD = wb_mem_to_reg;
    misalignSet = 1'b0;
    busSet      = 1'b0;
    if (accept && (!exIsMem || exMisalign)) begin
      wbValidD    = 1'b1;
      wbRegD      = ex_reg;
      wbResultD   = ex_result;
      wbMemToRegD = ex_mem_to_reg;
      wbLoadedD   = '0;
      wbRegWriteD = ex_reg_write && !exIsMem && (ex_reg != REG_W'(ZERO_REG));
      misalignSet = exIsMem;
    end else if (ackDone || timeoutHit) begin
      wbValidD    = 1'b1;
      wbRegD      = capReg;
      wbResultD   = capResult;
      wbMemToRegD = capMemToReg;
      wbLoadedD   = (ackDone && !capWrite) ? dm_rdata : '0;
      wbRegWriteD = ackDone && capRegWrite && (capReg != REG_W'(ZERO_REG));
      busSet      = !ackDone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ         <= IDLE;
      capReg         <= '0;
      capResult      <= '0;
      capStore       <= '0;
      capWrite       <= 1'b0;
      capMemToReg    <= 1'b0;
      capRegWrite    <= 1'b0;
      wb_valid       <= 1'b0;
      wb_reg         <= '0;
      wb_loaded_data <= '0;
      wb_result      <= '0;
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
      misalign_err   <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        capReg      <= ex_reg;
        capResult   <= ex_result;
        capStore    <= ex_store_data;
        capWrite    <= ex_mem_write;
        capMemToReg <= ex_mem_to_reg;
        capRegWrite <= ex_reg_write;
      end
      wb_valid       <= wbValidD;
      wb_reg         <= wbRegD;
      wb_loaded_data <= wbLoadedD;
      wb_result      <= wbResultD;
      wb_mem_to_reg  <= wbMemToRegD;
      wb_reg_write   <= wbRegWriteD;
      if (misalignSet) misalign_err <= 1'b1;
      if (busSet)      bus_err      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed table-driven bench for mem_access_stage with a small responding
// memory, plus hand sequences for back-to-back, stray ack and mid-access reset.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_reg;
  logic [63:0] ex_result, ex_store_data;
  logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic        dm_req, dm_we, dm_ack;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_mem_to_reg, wb_reg_write, misalign_err, bus_err;
  logic [4:0]  wb_reg;
  logic [63:0] wb_loaded_data, wb_result;

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_reg        (ex_reg),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_reg_write  (ex_reg_write),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_loaded_data(wb_loaded_data),
    .wb_result     (wb_result),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_write  (wb_reg_write),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] res;
    logic [63:0] sdata;
    logic        mr, mw, m2r, rw;
    int          ackDelay;  // 0 = never acknowledge
    logic [63:0] rdata;
    int          expLat;
    int          expReq;
    logic        expRw;
    logic [63:0] expLoaded;
    logic        expMis, expBus;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [4:0] rd, input logic [63:0] res, input logic [63:0] sdata,
                     input logic mr, input logic mw, input logic m2r, input logic rw,
                     input int ackDelay, input logic [63:0] rdata, input int expLat,
                     input int expReq, input logic expRw, input logic [63:0] expLoaded,
                     input logic expMis, input logic expBus);
    vec_t v;
    v.rd = rd; v.res = res; v.sdata = sdata; v.mr = mr; v.mw = mw; v.m2r = m2r; v.rw = rw;
    v.ackDelay = ackDelay; v.rdata = rdata; v.expLat = expLat; v.expReq = expReq;
    v.expRw = expRw; v.expLoaded = expLoaded; v.expMis = expMis; v.expBus = expBus;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] rd, input logic [63:0] res, input logic [63:0] sdata,
                       input logic mr, input logic mw, input logic m2r, input logic rw);
    ex_reg = rd; ex_result = res; ex_store_data = sdata;
    ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r; ex_reg_write = rw;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 1;
    int req = 0;
    drive(v.rd, v.res, v.sdata, v.mr, v.mw, v.m2r, v.rw);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    while (!wb_valid && lat < 40) begin
      if (dm_req) begin
        req++;
        chk($sformatf("v%0d dm_addr", idx), dm_addr, v.res);
        chk($sformatf("v%0d dm_we", idx), 64'(dm_we), 64'(v.mw));
        chk($sformatf("v%0d dm_wdata", idx), dm_wdata, v.sdata);
        chk($sformatf("v%0d ex_ready busy", idx), 64'(ex_ready), 64'd0);
        dm_ack   = (req == v.ackDelay);
        dm_rdata = dm_ack ? v.rdata : 64'hBAD0_BAD0;
      end
      step();
      dm_ack = 1'b0;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.expLat));
    chk($sformatf("v%0d req cycles", idx), 64'(req), 64'(v.expReq));
    chk($sformatf("v%0d wb_reg", idx), 64'(wb_reg), 64'(v.rd));
    chk($sformatf("v%0d wb_result", idx), wb_result, v.res);
    chk($sformatf("v%0d wb_loaded_data", idx), wb_loaded_data, v.expLoaded);
    chk($sformatf("v%0d wb_mem_to_reg", idx), 64'(wb_mem_to_reg), 64'(v.m2r));
    chk($sformatf("v%0d wb_reg_write", idx), 64'(wb_reg_write), 64'(v.expRw));
    chk($sformatf("v%0d misalign_err", idx), 64'(misalign_err), 64'(v.expMis));
    chk($sformatf("v%0d bus_err", idx), 64'(bus_err), 64'(v.expBus));
    chk($sformatf("v%0d ex_ready after", idx), 64'(ex_ready), 64'd1);
    step();
    chk($sformatf("v%0d wb_valid pulse", idx), 64'(wb_valid), 64'd0);
    chk($sformatf("v%0d bubble reg_write", idx), 64'(wb_reg_write), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    drive(5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    //  rd     res        sdata     mr mw m2r rw ack rdata         lat req rw loaded      mis bus
    add(5'd3,  64'h55,    64'h0,    0, 0, 0, 1, 0,  64'h0,         1,  0,  1, 64'h0,        0, 0);
    add(5'd5,  64'h100,   64'h0,    1, 0, 1, 1, 3,  64'hDEADBEEF,  4,  3,  1, 64'hDEADBEEF, 0, 0);
    add(5'd7,  64'h108,   64'h1234, 0, 1, 0, 0, 1,  64'h0,         2,  1,  0, 64'h0,        0, 0);
    add(5'd8,  64'h110,   64'h5A5A, 1, 1, 0, 0, 2,  64'hAAAA,      3,  2,  0, 64'h0,        0, 0);
    add(5'd9,  64'h118,   64'h0,    1, 0, 1, 1, 16, 64'h77,        17, 16, 1, 64'h77,       0, 0);
    add(5'd31, 64'h66,    64'h0,    0, 0, 0, 1, 0,  64'h0,         1,  0,  0, 64'h0,        0, 0);
    add(5'd31, 64'h120,   64'hBEEF, 0, 1, 0, 0, 1,  64'h0,         2,  1,  0, 64'h0,        0, 0);
    add(5'd4,  64'h103,   64'h0,    1, 0, 1, 1, 0,  64'h0,         1,  0,  0, 64'h0,        1, 0);
    add(5'd6,  64'h99,    64'h0,    0, 0, 0, 1, 0,  64'h0,         1,  0,  1, 64'h0,        1, 0);
    add(5'd10, 64'h200,   64'h0,    1, 0, 1, 1, 0,  64'h0,         17, 16, 0, 64'h0,        1, 1);
    add(5'd2,  64'hABC,   64'h0,    0, 0, 0, 1, 0,  64'h0,         1,  0,  1, 64'h0,        1, 1);

    #1;
    chk("reset ex_ready", 64'(ex_ready), 64'd0);
    chk("reset dm_req", 64'(dm_req), 64'd0);
    chk("reset wb_valid", 64'(wb_valid), 64'd0);
    chk("reset dm_addr", dm_addr, 64'd0);
    chk("reset errs", {62'd0, misalign_err, bus_err}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post-reset ex_ready", 64'(ex_ready), 64'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Back-to-back ALU ops: ex_valid held high across two edges.
    drive(5'd11, 64'h1111, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    ex_valid = 1'b1;
    step();
    chk("b2b first result", wb_result, 64'h1111);
    chk("b2b ready", 64'(ex_ready), 64'd1);
    drive(5'd12, 64'h2222, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("b2b second valid", 64'(wb_valid), 64'd1);
    chk("b2b second result", wb_result, 64'h2222);

    // Load acked in 1 with the next op already waiting: not accepted on the ack edge.
    drive(5'd13, 64'h300, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("wait dm_req", 64'(dm_req), 64'd1);
    drive(5'd14, 64'h3333, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    dm_ack = 1'b1; dm_rdata = 64'hC0FFEE;
    step();
    dm_ack = 1'b0;
    chk("ack edge wb_reg", 64'(wb_reg), 64'd13);
    chk("ack edge loaded", wb_loaded_data, 64'hC0FFEE);
    chk("ack edge dm_req low", 64'(dm_req), 64'd0);
    step();
    chk("next op accepted late", wb_result, 64'h3333);
    chk("next op valid", 64'(wb_valid), 64'd1);
    ex_valid = 1'b0;

    // Stray ack in IDLE is ignored.
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    chk("stray ack wb_valid", 64'(wb_valid), 64'd0);
    chk("stray ack dm_req", 64'(dm_req), 64'd0);

    // Reset during ACCESS drops everything immediately; instruction never retires.
    drive(5'd15, 64'h400, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    step();
    chk("pre-reset dm_req", 64'(dm_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset dm_req", 64'(dm_req), 64'd0);
    chk("async reset wb_valid", 64'(wb_valid), 64'd0);
    chk("async reset errs", {62'd0, misalign_err, bus_err}, 64'd0);
    chk("async reset wb_result", wb_result, 64'd0);
    dm_ack = 1'b1;
    step();
    dm_ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk("release ex_ready", 64'(ex_ready), 64'd1);
    chk("aborted never retires", 64'(wb_valid), 64'd0);
    chk("release dm_req", 64'(dm_req), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage, directly upstream of the write-back stage.
- Accepts one instruction at a time from EX/MEM, performs the data-memory load or store through a req/ack handshake, and registers the MEM/WB fields consumed by write-back: destination reg, loaded data, ALU result, MemToReg, RegWrite.
- Stalls EX while a memory access is outstanding. Detects misaligned accesses and bus timeouts.

Parameters:
- DATA_W, 64, data/result width
- ADDR_W, 64, address width (taken from ex_result)
- REG_W, 5, register index width
- ZERO_REG, 31, register index whose writes are suppressed (XZR)
- TIMEOUT, 16, max cycles waiting for dm_ack before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_ready  out  1  stage can accept this cycle
- ex_reg  in  REG_W  destination register
- ex_result  in  DATA_W  ALU result / memory address
- ex_store_data  in  DATA_W  store data
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_mem_to_reg  in  1  write-back selects loaded data
- ex_reg_write  in  1  write-back writes register file
- dm_req  out  1  memory request
- dm_we  out  1  request is a write
- dm_addr  out  ADDR_W  request address
- dm_wdata  out  DATA_W  write data
- dm_ack  in  1  request complete; dm_rdata valid this cycle for reads
- dm_rdata  in  DATA_W  read data
- wb_valid  out  1  MEM/WB holds a real instruction
- wb_reg  out  REG_W  MEM/WB destination register
- wb_loaded_data  out  DATA_W  MEM/WB loaded data
- wb_result  out  DATA_W  MEM/WB ALU result
- wb_mem_to_reg  out  1  MEM/WB MemToReg
- wb_reg_write  out  1  MEM/WB RegWrite
- misalign_err  out  1  sticky: misaligned access seen
- bus_err  out  1  sticky: dm_ack timeout seen

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; wait counter 0. Asserting reset mid-ACCESS drops dm_req immediately. The aborted instruction never reaches write-back.
- FSM states:
  - IDLE: ex_ready=1.
  - ACCESS: ex_ready=0.
- Accept occurs on ex_valid && ex_ready at a rising clk edge. All ex_* fields are captured internally.
- Address is misaligned when ex_result[2:0] != 0.
- Non-memory op (mem_read=mem_write=0), accepted in IDLE:
  - Next edge: wb_valid=1; wb_result=ex_result; wb_reg, wb_mem_to_reg, wb_reg_write copied; wb_loaded_data=0. Latency 1.
- Memory op, aligned:
  - Enter ACCESS. dm_req=1, driven from state. dm_we=captured mem_write; dm_addr=captured result; dm_wdata=captured store_data. All held stable until dm_ack.
  - On the cycle with dm_ack=1 in ACCESS:
    - Load: wb_loaded_data<=dm_rdata.
    - Store: wb_loaded_data<=0.
    - wb fields loaded, wb_valid<=1, state returns to IDLE. dm_req is 0 the cycle after ack.
  - Latency is 1+N, where N = cycles from dm_req rise to dm_ack, inclusive.
  - dm_ack outside ACCESS is ignored.
- Both mem_read and mem_write set: treated as a store; the read is ignored.
- Memory op, misaligned:
  - No dm_req.
  - Next edge: wb_valid=1 with wb_reg_write=0 (bubble carrying result).
  - misalign_err<=1, sticky until reset.
- Timeout:
  - Wait counter increments each ACCESS cycle without dm_ack.
  - When the counter reaches TIMEOUT: dm_req drops; bus_err<=1 (sticky); wb_valid<=1 with wb_reg_write=0; state IDLE.
  - dm_ack arriving on the TIMEOUT-th cycle wins; no error is raised.
- ZERO_REG: wb_reg_write is forced to 0 whenever ex_reg==ZERO_REG. A store to ZERO_REG is unaffected.
- Bubble: any edge with no completion sets wb_valid<=0 and wb_reg_write<=0. Other wb_* fields hold.
- wb_valid is a one-cycle pulse per instruction. Write-back consumes every pulse; there is no back-pressure from write-back.
- Back-to-back:
  - Accept in IDLE on the same edge that the previous non-memory op retires.
  - No accept on the edge that completes an ACCESS. The next instruction is accepted one cycle later.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W, REG_W, ZERO_REG.
  - FSM state enum mem_state_t {IDLE, ACCESS}.
  - Struct memwb_t {reg, loaded_data, result, mem_to_reg, reg_write, valid}, also used by write-back.
- One natural sub-module, mem_timeout_ctr: counter with clear/enable and a terminal flag at TIMEOUT.

Test Plan:
- ALU op, ex_reg=3, ex_result=0x55, reg_write=1, mem_to_reg=0 -> next cycle wb_valid=1, wb_reg=3, wb_result=0x55, wb_reg_write=1, no dm_req.
- Load from addr 0x100, memory acks after 3 cycles with rdata 0xDEADBEEF -> dm_req high 3 cycles, ex_ready=0 throughout, wb_loaded_data=0xDEADBEEF and wb_mem_to_reg=1 one edge after ack, wb_valid high exactly 1 cycle.
- Store to 0x108, data 0x1234, ack in 1 cycle -> dm_we=1, dm_addr=0x108, dm_wdata=0x1234 stable until ack; wb_valid=1 with wb_reg_write=0.
- Load to 0x103 -> no dm_req; misalign_err=1 and stays 1 across later instructions; wb_reg_write=0.
- Load with dm_ack never asserted, TIMEOUT=16 -> dm_req drops after 16 cycles, bus_err=1, ex_ready=1 again; a following ALU op completes normally.
- rst_n low while in ACCESS -> dm_req, wb_valid, all outputs 0 immediately; after release, ex_ready=1. ALU op with ex_reg=31 -> wb_reg_write=0.
